// File: rtl/mult_sched_pkg.sv
// Shared constants, step-control payload and step decoder for the
// 8x8 shift-add multiplier sequencer.
package mult_sched_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned NREQ   = 2;
  localparam int unsigned SH_W   = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    RESP = 3'd5
  } state_e;

  localparam logic [SH_W-1:0] SH0 = 2'd0;
  localparam logic [SH_W-1:0] SH4 = 2'd1;
  localparam logic [SH_W-1:0] SH8 = 2'd2;

  localparam logic NIB_HI = 1'b0;
  localparam logic NIB_LO = 1'b1;

  typedef struct packed {
    logic            sela;
    logic            selb;
    logic [SH_W-1:0] shift;
    logic            data_sel;
    logic            clk_en;
  } step_ctrl_t;

  // Datapath control for each partial-product step; all zero outside S0..S3.
  function automatic step_ctrl_t step_decode(input state_e s);
    step_ctrl_t c;
    c = '0;
    case (s)
      S0:      c = '{sela: NIB_LO, selb: NIB_LO, shift: SH0, data_sel: 1'b0, clk_en: 1'b1};
      S1:      c = '{sela: NIB_LO, selb: NIB_HI, shift: SH4, data_sel: 1'b1, clk_en: 1'b1};
      S2:      c = '{sela: NIB_HI, selb: NIB_LO, shift: SH4, data_sel: 1'b1, clk_en: 1'b1};
      S3:      c = '{sela: NIB_HI, selb: NIB_HI, shift: SH8, data_sel: 1'b1, clk_en: 1'b1};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Request, datapath-control and response signals of the multiplier sequencer.
interface mult_sched_if;
  import mult_sched_pkg::*;

  logic [NREQ-1:0]   req;
  logic [OP_W-1:0]   a0, b0, a1, b1;
  logic [NREQ-1:0]   ack;
  logic [OP_W-1:0]   op_a, op_b;
  logic              sela, selb;
  logic [SH_W-1:0]   sel_shifter;
  logic              data_sel;
  logic              clk_en;
  logic [PROD_W-1:0] acc_in;
  logic              rsp_valid;
  logic              rsp_id;
  logic [PROD_W-1:0] rsp_data;
  logic              rsp_ready;
  logic              busy;
  logic [2:0]        state;

  modport slave (
    input  req, a0, b0, a1, b1, acc_in, rsp_ready,
    output ack, op_a, op_b, sela, selb, sel_shifter, data_sel, clk_en,
           rsp_valid, rsp_id, rsp_data, busy, state
  );

  modport master (
    output req, a0, b0, a1, b1, acc_in, rsp_ready,
    input  ack, op_a, op_b, sela, selb, sel_shifter, data_sel, clk_en,
           rsp_valid, rsp_id, rsp_data, busy, state
  );

endinterface

// File: rtl/mult_sched_rr_arb2.sv
// Two-port round-robin arbiter; the pointer holds the last winner and the
// other port wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_c,
  output logic       ptr_c
);

  logic ptr_q;

  always_comb begin
    gnt_c = 2'b00;
    case (req_i)
      2'b01:   gnt_c = 2'b01;
      2'b10:   gnt_c = 2'b10;
      2'b11:   gnt_c = ptr_q ? 2'b01 : 2'b10;
      default: gnt_c = 2'b00;
    endcase
    ptr_c = (upd_i && (gnt_c != 2'b00)) ? gnt_c[1] : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= 1'b1;
    else      ptr_q <= ptr_c;
  end

endmodule

// File: rtl/mult_sched.sv
// Sequencer for the shared 4x4-nibble shift-add multiplier: arbitrates two
// requesters, steps the datapath through four partial products, returns the sum.
module mult_sched
  import mult_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mult_sched_if.slave  bus
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [OP_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  step_ctrl_t        ctrl_q, ctrl_d;
  logic              arb_upd;
  logic [NREQ-1:0]   arb_gnt;
  logic              arb_ptr;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (bus.req),
    .upd_i (arb_upd),
    .gnt_c (arb_gnt),
    .ptr_c (arb_ptr)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = '0;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    rsp_id_d = rsp_id_q;
    arb_upd  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          arb_upd  = 1'b1;
          ack_d    = arb_gnt;
          op_a_d   = arb_gnt[1] ? bus.a1 : bus.a0;
          op_b_d   = arb_gnt[1] ? bus.b1 : bus.b0;
          rsp_id_d = arb_ptr;
          state_d  = S0;
        end
      end
      S0:      state_d = S1;
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = RESP;
      RESP:    if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs for the coming cycle are decoded from the state being entered.
    ctrl_d      = step_decode(state_d);
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ack_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.op_a        = op_a_q;
  assign bus.op_b        = op_b_q;
  assign bus.sela        = ctrl_q.sela;
  assign bus.selb        = ctrl_q.selb;
  assign bus.sel_shifter = ctrl_q.shift;
  assign bus.data_sel    = ctrl_q.data_sel;
  assign bus.clk_en      = ctrl_q.clk_en;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.busy        = busy_q;
  assign bus.state       = state_q;
  // Accumulator is frozen in RESP, so its output is the product.
  assign bus.rsp_data    = bus.acc_in;

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: nibble datapath model around the DUT, products checked
// against a*b and round-robin winners against a last-winner reference.
module tb_mult_sched;

  logic clk;
  logic rst;
  mult_sched_if bus ();

  mult_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int last_win;
  logic [15:0] acc = 16'hBEEF;
  logic [5:0] step_tbl [4] = '{6'b110001, 6'b100111, 6'b010111, 6'b001011};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] nib(input logic [7:0] x, input logic sel);
    return sel ? x[3:0] : x[7:4];
  endfunction

  // Shared datapath: nibble muxes, 4x4 multiply, shifter, adder, accumulator.
  always @(posedge clk) begin
    if (bus.clk_en === 1'b1)
      acc <= (bus.data_sel ? acc : 16'h0000)
           + ((16'(nib(bus.op_a, bus.sela)) * 16'(nib(bus.op_b, bus.selb)))
              << (4 * int'(bus.sel_shifter)));
  end
  assign bus.acc_in = acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) check("shift_code_3", 32'(bus.sel_shifter !== 2'd3), 32'd1);
  end

  function automatic int exp_winner(input logic [1:0] r, input int last);
    if (r == 2'b11) return 1 - last;
    return r[1] ? 1 : 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check(tag, {bus.ack, bus.op_a, bus.op_b, bus.sela, bus.selb, bus.sel_shifter,
                bus.data_sel, bus.clk_en, bus.rsp_valid, bus.rsp_id, bus.busy, bus.state},
          32'd0);
  endtask

  // One full transaction starting from IDLE; late bits are raised while busy.
  task automatic txn(input logic [1:0] r, input logic [7:0] x0, input logic [7:0] y0,
                     input logic [7:0] x1, input logic [7:0] y1, input int hold,
                     input bit keep, input logic [1:0] late);
    int w;
    logic [1:0] g;
    logic [15:0] prod;
    w    = exp_winner(r, last_win);
    g    = (w == 1) ? 2'b10 : 2'b01;
    prod = (w == 1) ? 16'(x1) * 16'(y1) : 16'(x0) * 16'(y0);
    bus.a0 = x0; bus.b0 = y0; bus.a1 = x1; bus.b1 = y1;
    bus.req = r;
    bus.rsp_ready = 1'b0;
    tick();
    bus.req = (keep ? r : (r & ~g)) | late;
    for (int k = 0; k < 4; k++) begin
      check("step_state", 32'(bus.state), 32'(k + 1));
      check("step_ctrl", {bus.sela, bus.selb, bus.sel_shifter, bus.data_sel, bus.clk_en},
            step_tbl[k]);
      check("ack", 32'(bus.ack), (k == 0) ? 32'(g) : 32'd0);
      if (k == 0) begin
        check("operands", {bus.op_a, bus.op_b}, (w == 1) ? {x1, y1} : {x0, y0});
        check("rsp_id_early", 32'(bus.rsp_id), 32'(w));
      end
      tick();
    end
    check("resp", {bus.state, bus.busy, bus.rsp_valid, bus.clk_en, bus.rsp_id, bus.rsp_data},
          {3'd5, 1'b1, 1'b1, 1'b0, 1'(w), prod});
    for (int h = 0; h < hold; h++) begin
      tick();
      check("resp_hold", {bus.state, bus.rsp_valid, bus.clk_en, bus.rsp_id, bus.rsp_data},
            {3'd5, 1'b1, 1'b0, 1'(w), prod});
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("back_idle", {bus.state, bus.busy, bus.rsp_valid, bus.ack}, 32'd0);
    last_win = w;
  endtask

  initial begin
    rst = 1'b0;
    bus.req = 2'b00;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.rsp_ready = 1'b0;
    last_win = 1;
    tick();
    tick();
    check_reset_outputs("reset_values");
    rst = 1'b1;

    // Basic product and first tie-free grant.
    txn(2'b01, 8'h12, 8'h34, 8'h00, 8'h00, 0, 1'b0, 2'b00);
    // Consumer stalls for 10 cycles.
    txn(2'b10, 8'h00, 8'h00, 8'hC3, 8'h5A, 10, 1'b0, 2'b00);
    // Continuous tie: grants alternate 0,1,0.
    for (int i = 0; i < 3; i++)
      txn(2'b11, 8'hFF, 8'hFF, 8'h00, 8'hAB, i, 1'b1, 2'b00);

    // Port 1 raises req while port 0 is served; it is taken only once idle.
    txn(2'b01, 8'h21, 8'h43, 8'h9E, 8'h77, 0, 1'b0, 2'b10);
    txn(2'b10, 8'h21, 8'h43, 8'h9E, 8'h77, 1, 1'b0, 2'b00);
    bus.req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_extra_grant", {bus.ack, bus.state}, 32'd0);
    end

    // Reset while in S2, then a tie must go to port 0 again.
    bus.a0 = 8'h55; bus.b0 = 8'h66; bus.req = 2'b01;
    tick();
    tick();
    tick();
    check("mid_state_s2", 32'(bus.state), 32'd3);
    rst = 1'b0;
    tick();
    check_reset_outputs("mid_reset_values");
    rst = 1'b1;
    bus.req = 2'b00;
    last_win = 1;
    txn(2'b11, 8'h0F, 8'hF0, 8'h33, 8'h44, 0, 1'b0, 2'b00);

    // Random requests and operands.
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      txn(r, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
          int'($urandom_range(0, 2)), 1'b0, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
